// File: rtl/prim_rom_pkg.sv
// Shared types and helpers for the ROM front-end controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package prim_rom_pkg;

  // Controller phases: integrity sweep, final-word drain, then shared access.
  typedef enum logic [1:0] {
    SWEEP = 2'd0,
    DRAIN = 2'd1,
    ARB   = 2'd2
  } rom_ctrl_state_e;

  // Index width that stays at least one bit for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prim_rom_rr_arb.sv
// Round-robin pick: first requester at or above ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; at most one grant per evaluation.
// Ports: req (N requests), ptr (search start), gnt (one-hot), gnt_idx (binary index).
module prim_rom_rr_arb
  import prim_rom_pkg::*;
#(
  parameter int N    = 2,
  parameter int IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] gnt_idx
);

  logic found;

  // Pass one searches ptr..N-1; if nothing is found there, pass two picks the
  // lowest requester overall, which is the wrapped continuation of the search.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && (IdxW'(j) >= ptr)) begin
        gnt[j]  = 1'b1;
        gnt_idx = IdxW'(j);
        found   = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = IdxW'(j);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prim_rom_ctrl.sv
// ROM front end: post-reset XOR integrity sweep, then round-robin shared reads.
// Latency: grant combinational with req; rvalid/rdata one cycle after grant.
// Backpressure: requesters hold req/addr until granted; no grants during sweep.
// Ports: clk_i/rst_i; req_i/addr_i/gnt_o/rvalid_o/rdata_o requester side;
//        rom_req_o/rom_addr_o/rom_rdata_i ROM side; check_done_o/check_ok_o/checksum_o status.
module prim_rom_ctrl
  import prim_rom_pkg::*;
#(
  parameter int               Width       = 32,
  parameter int               Depth       = 2048,
  parameter int               NumReq      = 2,
  parameter logic [Width-1:0] ExpChecksum = '0,
  localparam int              Aw          = $clog2(Depth),
  localparam int              IdxW        = idx_width(NumReq)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumReq-1:0]    req_i,
  input  logic [NumReq*Aw-1:0] addr_i,
  output logic [NumReq-1:0]    gnt_o,
  output logic [NumReq-1:0]    rvalid_o,
  output logic [Width-1:0]     rdata_o,
  output logic                 rom_req_o,
  output logic [Aw-1:0]        rom_addr_o,
  input  logic [Width-1:0]     rom_rdata_i,
  output logic                 check_done_o,
  output logic                 check_ok_o,
  output logic [Width-1:0]     checksum_o
);

  rom_ctrl_state_e   state_q, state_d;
  logic [Aw-1:0]     cnt_q;
  logic [Width-1:0]  acc_q;
  logic [IdxW-1:0]   ptr_q;
  logic [NumReq-1:0] rvalid_q;
  logic              done_q;
  logic              acc_en;
  logic [NumReq-1:0] arb_gnt;
  logic [IdxW-1:0]   arb_idx;

  prim_rom_rr_arb #(
    .N    (NumReq),
    .IdxW (IdxW)
  ) u_arb (
    .req     (req_i),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    state_d    = state_q;
    rom_req_o  = 1'b0;
    rom_addr_o = '0;
    gnt_o      = '0;
    acc_en     = 1'b0;
    case (state_q)
      SWEEP: begin
        rom_req_o  = 1'b1;
        rom_addr_o = cnt_q;
        // Word k arrives the cycle after address k, so the very first sweep
        // cycle has nothing to fold yet.
        acc_en     = (cnt_q != '0);
        if (cnt_q == Aw'(Depth - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        acc_en  = 1'b1;
        state_d = ARB;
      end
      ARB: begin
        gnt_o     = arb_gnt;
        rom_req_o = |req_i;
        for (int k = 0; k < NumReq; k++) begin
          if (arb_gnt[k]) rom_addr_o = addr_i[k*Aw +: Aw];
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= SWEEP;
      cnt_q    <= '0;
      acc_q    <= '0;
      ptr_q    <= '0;
      rvalid_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      if (state_q == SWEEP) cnt_q <= cnt_q + 1'b1;
      if (acc_en) acc_q <= acc_q ^ rom_rdata_i;
      if (state_q == DRAIN) done_q <= 1'b1;
      rvalid_q <= gnt_o;
      if (|gnt_o) ptr_q <= (arb_idx == IdxW'(NumReq - 1)) ? '0 : arb_idx + 1'b1;
    end
  end

  assign rvalid_o     = rvalid_q;
  assign rdata_o      = rom_rdata_i;
  assign check_done_o = done_q;
  assign checksum_o   = acc_q;
  assign check_ok_o   = done_q && (acc_q == ExpChecksum);

  a_gnt_onehot0    : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o));
  a_rvalid_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rvalid_o));
  a_req_known      : assert property (@(posedge clk_i) disable iff (rst_i) !$isunknown(req_i));

endmodule

// File: tb/tb_prim_rom_ctrl.sv
// Bench for prim_rom_ctrl: two instances (matching / mismatching checksum) on one stimulus.
// Latency: n/a. Backpressure: requesters hold req/addr until granted.
module tb_prim_rom_ctrl;

  localparam int DEPTH = 16;
  localparam int NREQ  = 2;
  localparam int AW    = 4;
  localparam logic [31:0] EXP_A = 32'h10;
  localparam logic [31:0] EXP_B = 32'h11;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [NREQ-1:0]    req_i = '0;
  logic [NREQ*AW-1:0] addr_i = '0;

  logic [NREQ-1:0] gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [31:0]     rdata_a, rdata_b, rom_rdata_a, rom_rdata_b, csum_a, csum_b;
  logic            rom_req_a, rom_req_b, done_a, done_b, ok_a, ok_b;
  logic [AW-1:0]   rom_addr_a, rom_addr_b;

  logic [31:0] rom_m [DEPTH];
  int cur = 0;
  int phase = 0;
  int n_chk = 0;
  int n_fail = 0;
  int m_ptr = 0;
  logic [NREQ-1:0] m_prev_gnt = '0;
  logic [AW-1:0]   m_prev_addr = '0;
  logic [NREQ-1:0] granted_last = '0;

  always #5 clk_i = ~clk_i;

  prim_rom_ctrl #(.Width(32), .Depth(DEPTH), .NumReq(NREQ), .ExpChecksum(EXP_A)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .gnt_o(gnt_a),
    .rvalid_o(rvalid_a), .rdata_o(rdata_a), .rom_req_o(rom_req_a), .rom_addr_o(rom_addr_a),
    .rom_rdata_i(rom_rdata_a), .check_done_o(done_a), .check_ok_o(ok_a), .checksum_o(csum_a));

  prim_rom_ctrl #(.Width(32), .Depth(DEPTH), .NumReq(NREQ), .ExpChecksum(EXP_B)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .gnt_o(gnt_b),
    .rvalid_o(rvalid_b), .rdata_o(rdata_b), .rom_req_o(rom_req_b), .rom_addr_o(rom_addr_b),
    .rom_rdata_i(rom_rdata_b), .check_done_o(done_b), .check_ok_o(ok_b), .checksum_o(csum_b));

  // Registered ROMs holding words 0x1..0x10.
  initial for (int i = 0; i < DEPTH; i++) rom_m[i] = 32'(i + 1);
  always @(posedge clk_i) if (rom_req_a) rom_rdata_a <= rom_m[rom_addr_a];
  always @(posedge clk_i) if (rom_req_b) rom_rdata_b <= rom_m[rom_addr_b];

  // Cycle number after reset release: cycle 1 is the first with rst_i low.
  always @(posedge clk_i) cur <= rst_i ? 1 : cur + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s phase=%0d cycle=%0d: got %h expected %h", name, phase, cur, act, exp);
    end
  endtask

  // Reference model and compare, evaluated mid-cycle.
  always @(negedge clk_i) begin
    logic [NREQ-1:0] e_gnt;
    logic            e_req;
    logic [AW-1:0]   e_addr;
    logic [31:0]     e_csum;
    logic            e_done;
    int              e_idx;
    int              j;
    if (rst_i) begin
      m_ptr      = 0;
      m_prev_gnt = '0;
    end else begin
      e_gnt = '0; e_req = 1'b0; e_addr = '0; e_idx = 0;
      if (cur <= DEPTH) begin
        e_req  = 1'b1;
        e_addr = AW'(cur - 1);
      end else if (cur >= DEPTH + 2) begin
        for (int i = 0; i < NREQ; i++) begin
          j = (m_ptr + i) % NREQ;
          if (e_gnt == '0 && req_i[j]) begin
            e_gnt[j] = 1'b1;
            e_idx    = j;
          end
        end
        if (e_gnt != '0) begin
          e_req  = 1'b1;
          e_addr = addr_i[e_idx*AW +: AW];
        end
      end
      // Visible checksum in cycle c folds ROM words 0..c-3.
      e_csum = '0;
      for (int k = 0; k < DEPTH; k++) if (k < cur - 2) e_csum ^= rom_m[k];
      e_done = (cur >= DEPTH + 2);

      chk("gnt", 32'(gnt_a), 32'(e_gnt));
      chk("rom_req", 32'(rom_req_a), 32'(e_req));
      if (e_req) chk("rom_addr", 32'(rom_addr_a), 32'(e_addr));
      chk("rvalid", 32'(rvalid_a), 32'(m_prev_gnt));
      if (m_prev_gnt != '0) chk("rdata", rdata_a, rom_m[m_prev_addr]);
      chk("checksum", csum_a, e_csum);
      chk("done", 32'(done_a), 32'(e_done));
      chk("ok_a", 32'(ok_a), 32'(e_done && (e_csum == EXP_A)));
      chk("checksum_b", csum_b, e_csum);
      chk("done_b", 32'(done_b), 32'(e_done));
      chk("ok_b", 32'(ok_b), 32'(e_done && (e_csum == EXP_B)));

      // Hand-computed anchors.
      if (phase == 1 && cur == 5)  chk("lit_sweep_gnt", 32'(gnt_a), 32'h0);
      if (phase == 1 && cur == 5)  chk("lit_sweep_addr", 32'(rom_addr_a), 32'h4);
      if (phase == 1 && cur == 17) chk("lit_done_early", 32'(done_a), 32'h0);
      if (phase == 1 && cur == 18) begin
        chk("lit_gnt18", 32'(gnt_a), 32'h2);
        chk("lit_checksum", csum_a, 32'h10);
        chk("lit_ok_a", 32'(ok_a), 32'h1);
        chk("lit_ok_b", 32'(ok_b), 32'h0);
      end
      if (phase == 1 && cur == 19) chk("lit_rvalid19", 32'(rvalid_a), 32'h2);
      if (phase == 1 && cur == 19) chk("lit_rdata19", rdata_a, 32'h8);
      if (phase == 2 && cur >= 18 && cur <= 21) chk("lit_alt_gnt", 32'(gnt_a), (cur % 2 == 0) ? 32'h1 : 32'h2);
      if (phase == 2 && cur >= 19 && cur <= 22) chk("lit_alt_rdata", rdata_a, (cur % 2 == 1) ? 32'h4 : 32'h8);
      if (phase == 3 && cur >= 19 && cur <= 22) chk("lit_single_rvalid", 32'(rvalid_a), 32'h1);
      if (phase == 3 && cur >= 19 && cur <= 22) chk("lit_single_rdata", rdata_a, 32'(cur - 18));
      if (phase == 5 && cur == 1) begin
        chk("lit_rst_rvalid", 32'(rvalid_a), 32'h0);
        chk("lit_rst_addr", 32'(rom_addr_a), 32'h0);
        chk("lit_rst_done", 32'(done_a), 32'h0);
      end

      m_prev_gnt  = e_gnt;
      m_prev_addr = e_addr;
      if (e_gnt != '0) m_ptr = (e_idx + 1) % NREQ;
    end
    granted_last = gnt_a;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    req_i = '0;
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic goto(input int n);
    for (int g = 0; g < 200 && cur != n; g++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
    $fatal(1);
  end

  initial begin
    // Requester 1 waits from mid-sweep; served in the first arbitration cycle.
    phase = 1;
    do_reset();
    goto(5);
    addr_i = {4'd7, 4'd0};
    req_i  = 2'b10;
    goto(19);
    req_i  = 2'b00;
    goto(22);

    // Two requesters held continuously alternate.
    phase = 2;
    do_reset();
    goto(18);
    addr_i = {4'd7, 4'd3};
    req_i  = 2'b11;
    goto(24);
    req_i  = 2'b00;
    goto(26);

    // Single requester, back-to-back grants.
    phase = 3;
    do_reset();
    goto(18);
    for (int i = 0; i < 4; i++) begin
      req_i       = 2'b01;
      addr_i[3:0] = AW'(i);
      step();
    end
    req_i = 2'b00;
    goto(24);

    // Random traffic obeying hold-until-granted.
    phase = 4;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (req_i[k] && granted_last[k]) begin
          req_i[k] = ($urandom_range(0, 1) == 1);
          addr_i[k*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
        end else if (!req_i[k] && $urandom_range(0, 99) < 40) begin
          req_i[k] = 1'b1;
          addr_i[k*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
        end
      end
      step();
    end

    // Reset the cycle after a grant: response dropped, sweep restarts.
    phase = 5;
    req_i       = 2'b01;
    addr_i[3:0] = 4'd5;
    step();
    req_i = 2'b00;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    goto(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
